// File: rtl/seq_adder_nbit_if.sv
// Handshake and operand/result bundle for seq_adder_nbit.
// The ovf signal exists only when SEQ_ADDER_OVF_EN is defined.
interface seq_adder_nbit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             cout;
`ifdef SEQ_ADDER_OVF_EN
  logic             ovf;

  modport master (output start, a, b, cin, sub, input busy, done, s, cout, ovf);
  modport slave  (input start, a, b, cin, sub, output busy, done, s, cout, ovf);
`else
  modport master (output start, a, b, cin, sub, input busy, done, s, cout);
  modport slave  (input start, a, b, cin, sub, output busy, done, s, cout);
`endif
endinterface

// File: rtl/seq_adder_nbit.sv
// Digit-serial adder/subtractor: WIDTH-bit result, DIGIT bits per clock, start/busy/done handshake.
// Define SEQ_ADDER_OVF_EN to add the registered signed-overflow output.
module seq_adder_nbit #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4   // must divide WIDTH exactly
) (
  input  logic              clk,
  input  logic              rst,
  seq_adder_nbit_if.slave   bus
);

  localparam int NDIG  = WIDTH / DIGIT;
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, res_q, s_q;
  logic             carry_q, busy_q, done_q, cout_q, ovf_q;
  logic [CNT_W-1:0] cnt_q;

  logic [DIGIT:0]   sum_d;
  logic [WIDTH-1:0] res_d;
  logic             last_d, ovf_d;

  // NOTE: every variable gets a value on every path through always_comb, so no latch is inferred.
  always_comb begin
    sum_d  = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
    res_d  = (res_q >> DIGIT) | (WIDTH'(sum_d[DIGIT-1:0]) << (WIDTH - DIGIT));
    last_d = (cnt_q == CNT_W'(NDIG - 1));
    // Same-sign operands giving an opposite-sign MSB is carry-in xor carry-out of the MSB.
    ovf_d  = (a_q[DIGIT-1] == b_q[DIGIT-1]) && (sum_d[DIGIT-1] != a_q[DIGIT-1]);
  end

  // NOTE: the datapath registers are reset as well, so an aborted run leaves no stale operand bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b ^ {WIDTH{bus.sub}};
            carry_q <= bus.cin ^ bus.sub;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q     <= a_q >> DIGIT;
          b_q     <= b_q >> DIGIT;
          carry_q <= sum_d[DIGIT];
          res_q   <= res_d;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (last_d) begin
            s_q     <= res_d;
            cout_q  <= sum_d[DIGIT];
            ovf_q   <= ovf_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.s    = s_q;
  assign bus.cout = cout_q;
`ifdef SEQ_ADDER_OVF_EN
  assign bus.ovf  = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_q ^ ovf_d;
`endif

endmodule

// File: tb/tb_seq_adder_nbit.sv
// Self-checking bench for seq_adder_nbit: 8/2 directed vectors and handshake/reset sequences,
// plus random ops on 32/32 and 32/1 against an arithmetic reference model.
module tb_seq_adder_nbit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Index 0: WIDTH=8 DIGIT=2, 1: WIDTH=32 DIGIT=32, 2: WIDTH=32 DIGIT=1
  logic        start_v[3];
  logic [31:0] a_v[3], b_v[3];
  logic        cin_v[3], sub_v[3];
  logic        busy_v[3], done_v[3], cout_v[3], ovf_v[3];
  logic [31:0] s_v[3];

  int n_tests = 0;
  int n_fail  = 0;

  seq_adder_nbit_if #(.WIDTH(8))  if8  ();
  seq_adder_nbit_if #(.WIDTH(32)) if32 ();
  seq_adder_nbit_if #(.WIDTH(32)) if1  ();

  seq_adder_nbit #(.WIDTH(8),  .DIGIT(2))  u_dut8  (.clk(clk), .rst(rst), .bus(if8.slave));
  seq_adder_nbit #(.WIDTH(32), .DIGIT(32)) u_dut32 (.clk(clk), .rst(rst), .bus(if32.slave));
  seq_adder_nbit #(.WIDTH(32), .DIGIT(1))  u_dut1  (.clk(clk), .rst(rst), .bus(if1.slave));

  assign if8.start  = start_v[0];
  assign if8.a      = a_v[0][7:0];
  assign if8.b      = b_v[0][7:0];
  assign if8.cin    = cin_v[0];
  assign if8.sub    = sub_v[0];
  assign busy_v[0]  = if8.busy;
  assign done_v[0]  = if8.done;
  assign s_v[0]     = {24'd0, if8.s};
  assign cout_v[0]  = if8.cout;

  assign if32.start = start_v[1];
  assign if32.a     = a_v[1];
  assign if32.b     = b_v[1];
  assign if32.cin   = cin_v[1];
  assign if32.sub   = sub_v[1];
  assign busy_v[1]  = if32.busy;
  assign done_v[1]  = if32.done;
  assign s_v[1]     = if32.s;
  assign cout_v[1]  = if32.cout;

  assign if1.start  = start_v[2];
  assign if1.a      = a_v[2];
  assign if1.b      = b_v[2];
  assign if1.cin    = cin_v[2];
  assign if1.sub    = sub_v[2];
  assign busy_v[2]  = if1.busy;
  assign done_v[2]  = if1.done;
  assign s_v[2]     = if1.s;
  assign cout_v[2]  = if1.cout;

`ifdef SEQ_ADDER_OVF_EN
  assign ovf_v[0] = if8.ovf;
  assign ovf_v[1] = if32.ovf;
  assign ovf_v[2] = if1.ovf;
`else
  assign ovf_v[0] = 1'b0;
  assign ovf_v[1] = 1'b0;
  assign ovf_v[2] = 1'b0;
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the mathematical values.
  function automatic void ref_model(input int w, input logic [31:0] a, input logic [31:0] b,
                                    input logic cin, input logic sub,
                                    output logic [31:0] s, output logic cout, output logic ovf);
    longint mod  = longint'(1) << w;
    longint ua   = longint'(a) & (mod - 1);
    longint ub   = longint'(b) & (mod - 1);
    longint sa   = (ua >= mod / 2) ? ua - mod : ua;
    longint sb   = (ub >= mod / 2) ? ub - mod : ub;
    longint c    = cin ? 1 : 0;
    longint r, sr;
    if (sub) begin
      r    = ua - ub - c;
      cout = (r >= 0);
      sr   = sa - sb - c;
    end else begin
      r    = ua + ub + c;
      cout = (r >= mod);
      sr   = sa + sb + c;
    end
    s   = 32'(r & (mod - 1));
    ovf = (sr > mod / 2 - 1) || (sr < -(mod / 2));
  endfunction

  // Issue one op on DUT k; lat counts clock edges after the accepting edge until DONE is seen.
  task automatic run_op(input int k, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic sub, output int lat);
    @(negedge clk);
    a_v[k] = a; b_v[k] = b; cin_v[k] = cin; sub_v[k] = sub; start_v[k] = 1'b1;
    @(negedge clk);
    start_v[k] = 1'b0;
    check($sformatf("busy_after_start[%0d]", k), 64'(busy_v[k]), 64'd1);
    lat = 0;
    while (!done_v[k] && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_result(input string tag, input int k, input logic [31:0] es,
                              input logic ec, input logic eo);
    check({tag, "_s"},    64'(s_v[k]),    64'(es));
    check({tag, "_cout"}, 64'(cout_v[k]), 64'(ec));
    check({tag, "_busy"}, 64'(busy_v[k]), 64'd0);
`ifdef SEQ_ADDER_OVF_EN
    check({tag, "_ovf"},  64'(ovf_v[k]),  64'(eo));
`else
    if (eo === 1'bx) check({tag, "_ovf"}, 64'(ovf_v[k]), 64'd0);
`endif
  endtask

  typedef struct {
    logic [7:0] a, b;
    logic       cin, sub;
    logic [7:0] s;
    logic       cout, ovf;
  } vec_t;

  initial begin
    vec_t        vecs[8];
    int          lat;
    int          seen_done;
    logic [31:0] ra, rb, es;
    logic        rc, rs, ec, eo;

    vecs[0] = '{8'h5A, 8'h3C, 1'b1, 1'b0, 8'h97, 1'b0, 1'b1};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[3] = '{8'h80, 8'h01, 1'b1, 1'b1, 8'h7E, 1'b1, 1'b1};
    vecs[4] = '{8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[5] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};
    vecs[6] = '{8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0};
    vecs[7] = '{8'h20, 8'h10, 1'b0, 1'b1, 8'h10, 1'b1, 1'b0};

    for (int k = 0; k < 3; k++) begin
      start_v[k] = 1'b0; a_v[k] = '0; b_v[k] = '0; cin_v[k] = 1'b0; sub_v[k] = 1'b0;
    end

    // Reset state
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_busy[%0d]", k), 64'(busy_v[k]), 64'd0);
      check($sformatf("rst_done[%0d]", k), 64'(done_v[k]), 64'd0);
      check($sformatf("rst_s[%0d]", k),    64'(s_v[k]),    64'd0);
      check($sformatf("rst_cout[%0d]", k), 64'(cout_v[k]), 64'd0);
      check($sformatf("rst_ovf[%0d]", k),  64'(ovf_v[k]),  64'd0);
    end
    rst = 1'b0;

    // Directed table on the 8-bit / 2-bit-digit instance
    foreach (vecs[i]) begin
      run_op(0, 32'(vecs[i].a), 32'(vecs[i].b), vecs[i].cin, vecs[i].sub, lat);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'd4);
      check_result($sformatf("vec%0d", i), 0, 32'(vecs[i].s), vecs[i].cout, vecs[i].ovf);
      @(negedge clk);
      check($sformatf("vec%0d_done_width", i), 64'(done_v[0]), 64'd0);
    end

    // Handshake: START while busy is ignored; START held through DONE is accepted there
    @(negedge clk);
    a_v[0] = 32'h5A; b_v[0] = 32'h3C; cin_v[0] = 1'b1; sub_v[0] = 1'b0; start_v[0] = 1'b1;
    @(negedge clk);                                  // after accepting edge e0
    start_v[0] = 1'b0;
    @(negedge clk);                                  // after e1
    a_v[0] = 32'h00; b_v[0] = 32'h00; cin_v[0] = 1'b0; start_v[0] = 1'b1;
    @(negedge clk);                                  // after e2
    a_v[0] = 32'hFF; b_v[0] = 32'h01;
    check("hs_s_stable_in_run", 64'(s_v[0]), 64'h10);
    @(negedge clk);                                  // after e3
    check("hs_no_early_done", 64'(done_v[0]), 64'd0);
    @(negedge clk);                                  // after e4
    check("hs_done", 64'(done_v[0]), 64'd1);
    check_result("hs_first", 0, 32'h97, 1'b0, 1'b1);
    @(negedge clk);                                  // after e5: second op accepted
    start_v[0] = 1'b0;
    check("hs_b2b_busy", 64'(busy_v[0]), 64'd1);
    check("hs_b2b_done_low", 64'(done_v[0]), 64'd0);
    lat = 0;
    while (!done_v[0] && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("hs_b2b_latency", 64'(lat), 64'd4);
    check_result("hs_second", 0, 32'h00, 1'b1, 1'b0);

    // Reset two cycles into a run: outputs clear asynchronously, no DONE afterwards
    run_op(0, 32'h5A, 32'h3C, 1'b1, 1'b0, lat);
    check_result("pre_rst", 0, 32'h97, 1'b0, 1'b1);
    @(negedge clk);
    a_v[0] = 32'h7F; b_v[0] = 32'h01; cin_v[0] = 1'b0; start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 64'(busy_v[0]), 64'd0);
    check("arst_done", 64'(done_v[0]), 64'd0);
    check("arst_s",    64'(s_v[0]),    64'd0);
    check("arst_cout", 64'(cout_v[0]), 64'd0);
    check("arst_ovf",  64'(ovf_v[0]),  64'd0);
    @(negedge clk);
    rst = 1'b0;
    seen_done = 0;
    repeat (8) begin
      @(negedge clk);
      if (done_v[0] || busy_v[0]) seen_done++;
    end
    check("arst_no_done_after", 64'(seen_done), 64'd0);
    run_op(0, 32'h10, 32'h20, 1'b0, 1'b1, lat);
    check("post_rst_latency", 64'(lat), 64'd4);
    check_result("post_rst", 0, 32'hF0, 1'b0, 1'b0);

    // Random ops on the single-digit and bit-serial 32-bit instances
    for (int k = 1; k < 3; k++) begin
      for (int n = 0; n < 1000; n++) begin
        ra = $urandom; rb = $urandom;
        rc = 1'($urandom_range(1)); rs = 1'($urandom_range(1));
        if (n == 0) begin ra = 32'hFFFF_FFFF; rb = 32'h0; rc = 1'b1; rs = 1'b0; end
        if (n == 1) begin ra = 32'h8000_0000; rb = 32'h1; rc = 1'b0; rs = 1'b1; end
        ref_model(32, ra, rb, rc, rs, es, ec, eo);
        run_op(k, ra, rb, rc, rs, lat);
        check($sformatf("rnd%0d_%0d_latency", k, n), 64'(lat), (k == 1) ? 64'd1 : 64'd32);
        check_result($sformatf("rnd%0d_%0d", k, n), k, es, ec, eo);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_adder_nbit.md
Name: seq_adder_nbit

Overview:
- Parametrised digit-serial adder/subtractor; successor to the single-bit full adder cell in the ALU.
- Computes a WIDTH-bit sum or difference DIGIT bits per clock, with a start/busy/done handshake.
- Sits beside the combinational ALU datapath as the area-cheap arithmetic unit for wide operands.

Parameters:
- WIDTH, 32, operand and result width in bits; must be >= 1.
- DIGIT, 4, bits processed per cycle; must divide WIDTH exactly; NDIG = WIDTH/DIGIT.

Ports:
- CLK  in  1  clock, rising-edge active.
- RST  in  1  asynchronous reset, active-high.
- START  in  1  request; sampled only when idle.
- A  in  WIDTH  operand A, captured on accepted START.
- B  in  WIDTH  operand B, captured on accepted START.
- CIN  in  1  carry-in (add) / borrow-in (subtract), captured on accepted START.
- SUB  in  1  0 = add, 1 = subtract, captured on accepted START.
- BUSY  out  1  high while an operation is in progress.
- DONE  out  1  one-cycle pulse when results update.
- S  out  WIDTH  result, held until the next completion.
- COUT  out  1  raw carry-out of the MSB digit.

Behaviour:
- Reset (async, RST=1): state IDLE; BUSY=0, DONE=0, S=0, COUT=0 (and OVF=0); internal shift registers, carry and digit counter cleared.
- States:
  - IDLE: START=1 at a rising edge latches the operands and moves to RUN. Latched values: A, B^{WIDTH{SUB}}, carry = CIN^SUB, digit counter = 0. BUSY goes 1 at that same edge.
  - RUN: at each edge, add the low DIGIT bits of both operand shift registers plus carry. Shift the DIGIT-bit sum into the result shift register from the MSB side. Shift the operands right by DIGIT, update carry, increment the counter.
  - RUN exit: at the edge that processes digit NDIG-1, S and COUT load from the final values, BUSY goes 0, DONE goes 1 for exactly one cycle, and state returns to IDLE.
- Arithmetic:
  - SUB=0: S = A+B+CIN.
  - SUB=1: S = A-B-CIN, computed as A + ~B + ~CIN.
  - COUT=1 under subtract means no borrow.
  - All results are modulo 2^WIDTH.
- Latency: START accepted at edge 0, DONE high after edge NDIG, so there are exactly NDIG cycles from START to DONE. Throughput is one operation per NDIG cycles.
- Degenerate case DIGIT=WIDTH: NDIG=1, so DONE follows START by one cycle.
- START while BUSY=1: ignored; operands and SUB are not re-sampled.
- START during the DONE cycle: state is IDLE, so it is accepted, giving back-to-back operations with no bubble.
- Output stability: S and COUT do not change during RUN; they change only at completion or reset.
- RST mid-RUN: aborts immediately to reset values; no DONE pulse is ever produced for the aborted operation.
- Inputs A, B, CIN, SUB are don't-care except at the accepting edge.

Optional Feature:
- Macro SEQ_ADDER_OVF_EN.
- Defined:
  - Adds port OVF (out, 1): signed two's-complement overflow.
  - OVF = carry into MSB XOR carry out of MSB, computed within the final digit.
  - Registered and updated together with S and COUT; reset 0; held until the next completion.
- Undefined: no OVF port and no overflow logic; all other behaviour is identical.

Test Plan:
- WIDTH=8, DIGIT=2: A=8'h5A, B=8'h3C, CIN=1, SUB=0, START pulse -> BUSY for 4 cycles, DONE on the 4th edge, S=8'h97, COUT=0, OVF=1.
- WIDTH=8, DIGIT=2: A=8'hFF, B=8'h01, CIN=0, add -> S=8'h00, COUT=1, OVF=0. Repeat with A=8'h7F -> S=8'h80, COUT=0, OVF=1.
- WIDTH=8, DIGIT=2: A=8'h10, B=8'h20, CIN=0, SUB=1 -> S=8'hF0, COUT=0 (borrow), OVF=0. A=8'h20, B=8'h10 -> S=8'h10, COUT=1.
- Handshake: while BUSY, pulse START with A=8'h00, B=8'h00 -> ignored, first result still reported. Hold START=1 through the DONE cycle with new operands -> second op accepted at the DONE edge, second DONE exactly 4 cycles later.
- Reset: assert RST asynchronously two cycles into RUN -> BUSY, DONE, S, COUT, OVF go 0 without waiting for a clock edge, and no DONE appears afterwards. A fresh START after release operates normally.
- WIDTH=32, DIGIT=32 and WIDTH=32, DIGIT=1: random A/B/CIN/SUB against a reference model, 1000 ops each.
  - DONE latency is 1 and 32 cycles respectively.
  - All S/COUT (and OVF) values match the model.
